// File: rtl/hockey_pkg.sv
// Shared definitions for the air-hockey datapath: match state encoding,
// winner codes, default serve/center coordinates and a saturating score
// increment used by the match sequencer.
package hockey_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GOAL  = 3'd3,
    ST_OVER  = 3'd4
  } match_state_t;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;

  localparam logic [9:0] DEF_CENTER_X = 10'd464;
  localparam logic [9:0] DEF_CENTER_Y = 10'd271;
  localparam logic [9:0] DEF_SERVE1_X = 10'd327;
  localparam logic [9:0] DEF_SERVE2_X = 10'd600;
  localparam logic [9:0] DEF_SERVE_Y  = 10'd271;

  // Score increment that sticks at the 3-bit maximum.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    if (v == 3'd7) begin
      return 3'd7;
    end else begin
      return v + 3'd1;
    end
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Pause timer counting frame ticks.
// Ports:
//   clk        system clock
//   clr        synchronous active-high reset
//   restart    clears the count (asserted on the edge that enters a new state)
//   frame_tick tick to count (already gated to the pausing states by the caller)
//   done       registered one-cycle pulse in the cycle after the N-th tick
module frame_timer #(
  parameter int unsigned N = 60
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  input  logic frame_tick,
  output logic done
);

  localparam logic [7:0] LAST = 8'(N - 1);

  logic [7:0] count;

  // Tick counter with registered terminal-count pulse; restart wins over a tick.
  always_ff @(posedge clk) begin
    if (clr || restart) begin
      count <= 8'd0;
      done  <= 1'b0;
    end else if (frame_tick) begin
      if (count == LAST) begin
        count <= 8'd0;
        done  <= 1'b1;
      end else begin
        count <= count + 8'd1;
        done  <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer: runs idle/serve/play/goal/over flow, gates the puck mover,
// loads serve positions, keeps scores and declares the winner.
// Ports:
//   clk, clr            clock, synchronous active-high reset
//   frame_tick          one-cycle frame pulse
//   start               one-cycle start button pulse
//   goal1, goal2        goal rectangle occupancy levels from the mover
//   move_en             mover may advance the puck (PLAY only)
//   serve_load          one-cycle pulse on SERVE entry
//   serve_x, serve_y    serve position
//   score1, score2      player scores
//   winner              0 none, 1 player 1, 2 player 2
//   state               current state encoding
module match_ctrl
  import hockey_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter logic [9:0]  CENTER_X     = DEF_CENTER_X,
  parameter logic [9:0]  CENTER_Y     = DEF_CENTER_Y,
  parameter logic [9:0]  SERVE1_X     = DEF_SERVE1_X,
  parameter logic [9:0]  SERVE2_X     = DEF_SERVE2_X,
  parameter logic [9:0]  SERVE_Y      = DEF_SERVE_Y
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       goal1,
  input  logic       goal2,
  output logic       move_en,
  output logic       serve_load,
  output logic [9:0] serve_x,
  output logic [9:0] serve_y,
  output logic [2:0] score1,
  output logic [2:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [2:0] WIN = 3'(WIN_SCORE);

  match_state_t cur_state, nxt_state;
  logic [2:0]   score1_nxt, score2_nxt;
  logic [1:0]   winner_nxt;
  logic [9:0]   serve_x_nxt, serve_y_nxt;
  logic         goal1_q, goal2_q;
  logic         goal1_rise, goal2_rise;
  logic         pause_tick, restart, pause_done;

  assign goal1_rise = goal1 & ~goal1_q;
  assign goal2_rise = goal2 & ~goal2_q;
  assign pause_tick = frame_tick & ((cur_state == ST_SERVE) || (cur_state == ST_GOAL));
  // Every state change is a state entry, so the pause count restarts there.
  assign restart    = (nxt_state != cur_state);
  assign state      = cur_state;

  frame_timer #(.N(PAUSE_FRAMES)) u_timer (
    .clk        (clk),
    .clr        (clr),
    .restart    (restart),
    .frame_tick (pause_tick),
    .done       (pause_done)
  );

  // Next-state, score, winner and serve-position logic.
  always_comb begin
    nxt_state   = cur_state;
    score1_nxt  = score1;
    score2_nxt  = score2;
    winner_nxt  = winner;
    serve_x_nxt = serve_x;
    serve_y_nxt = serve_y;
    case (cur_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          nxt_state   = ST_SERVE;
          score1_nxt  = 3'd0;
          score2_nxt  = 3'd0;
          winner_nxt  = WINNER_NONE;
          serve_x_nxt = CENTER_X;
          serve_y_nxt = CENTER_Y;
        end else begin
          nxt_state = cur_state;
        end
      end
      ST_SERVE: begin
        if (pause_done) begin
          nxt_state = ST_PLAY;
        end else begin
          nxt_state = ST_SERVE;
        end
      end
      ST_PLAY: begin
        // goal1 has priority when both rise together.
        if (goal1_rise) begin
          nxt_state   = ST_GOAL;
          score1_nxt  = sat_inc3(score1);
          serve_x_nxt = SERVE1_X;
          serve_y_nxt = SERVE_Y;
        end else if (goal2_rise) begin
          nxt_state   = ST_GOAL;
          score2_nxt  = sat_inc3(score2);
          serve_x_nxt = SERVE2_X;
          serve_y_nxt = SERVE_Y;
        end else begin
          nxt_state = ST_PLAY;
        end
      end
      ST_GOAL: begin
        if (pause_done) begin
          if (score1 == WIN) begin
            nxt_state  = ST_OVER;
            winner_nxt = WINNER_P1;
          end else if (score2 == WIN) begin
            nxt_state  = ST_OVER;
            winner_nxt = WINNER_P2;
          end else begin
            nxt_state = ST_SERVE;
          end
        end else begin
          nxt_state = ST_GOAL;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; outputs are derived from the next state so
  // they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (clr) begin
      cur_state  <= ST_IDLE;
      score1     <= 3'd0;
      score2     <= 3'd0;
      winner     <= WINNER_NONE;
      serve_x    <= CENTER_X;
      serve_y    <= CENTER_Y;
      move_en    <= 1'b0;
      serve_load <= 1'b0;
      goal1_q    <= 1'b0;
      goal2_q    <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      score1     <= score1_nxt;
      score2     <= score2_nxt;
      winner     <= winner_nxt;
      serve_x    <= serve_x_nxt;
      serve_y    <= serve_y_nxt;
      move_en    <= (nxt_state == ST_PLAY);
      serve_load <= (nxt_state == ST_SERVE) && (cur_state != ST_SERVE);
      goal1_q    <= goal1;
      goal2_q    <= goal2;
    end
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Directed self-checking bench for match_ctrl: default-parameter instance for
// the match flow plus a PAUSE_FRAMES=1 instance for the minimum pause.
module tb_match_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic frame_tick = 1'b0, start = 1'b0, goal1 = 1'b0, goal2 = 1'b0;
  logic move_en, serve_load;
  logic [9:0] serve_x, serve_y;
  logic [2:0] score1, score2, state;
  logic [1:0] winner;

  logic tick_b = 1'b0, start_b = 1'b0, goal_b = 1'b0;
  logic move_en_b, serve_load_b;
  logic [9:0] serve_x_b, serve_y_b;
  logic [2:0] score1_b, score2_b, state_b;
  logic [1:0] winner_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  match_ctrl dut (
    .clk(clk), .clr(clr), .frame_tick(frame_tick), .start(start),
    .goal1(goal1), .goal2(goal2), .move_en(move_en), .serve_load(serve_load),
    .serve_x(serve_x), .serve_y(serve_y), .score1(score1), .score2(score2),
    .winner(winner), .state(state)
  );

  match_ctrl #(.PAUSE_FRAMES(1)) dut_min (
    .clk(clk), .clr(clr), .frame_tick(tick_b), .start(start_b),
    .goal1(goal_b), .goal2(goal_b), .move_en(move_en_b), .serve_load(serve_load_b),
    .serve_x(serve_x_b), .serve_y(serve_y_b), .score1(score1_b), .score2(score2_b),
    .winner(winner_b), .state(state_b)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each tick: one cycle high, one cycle low.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(1);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " state"}, int'(state), 0);
    chk({tag, " score1"}, int'(score1), 0);
    chk({tag, " score2"}, int'(score2), 0);
    chk({tag, " winner"}, int'(winner), 0);
    chk({tag, " move_en"}, int'(move_en), 0);
    chk({tag, " serve_load"}, int'(serve_load), 0);
    chk({tag, " serve_x"}, int'(serve_x), 464);
    chk({tag, " serve_y"}, int'(serve_y), 271);
  endtask

  task automatic test_reset;
    clr = 1'b1;
    step(2);
    clr = 1'b0;
    check_reset_values("reset");
    chk("reset min state", int'(state_b), 0);
  endtask

  task automatic test_kickoff;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("kick state", int'(state), 1);
    chk("kick serve_load", int'(serve_load), 1);
    chk("kick serve_x", int'(serve_x), 464);
    chk("kick serve_y", int'(serve_y), 271);
    chk("kick move_en", int'(move_en), 0);
    step(1);
    chk("kick serve_load once", int'(serve_load), 0);
    ticks(59);
    chk("kick state after 59", int'(state), 1);
    chk("kick move_en after 59", int'(move_en), 0);
    ticks(1);
    chk("kick state after 60", int'(state), 2);
    chk("kick move_en after 60", int'(move_en), 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("start ignored in play", int'(state), 2);
  endtask

  task automatic test_single_goal;
    goal1 = 1'b1;
    step(1);
    goal1 = 1'b0;
    chk("goal1 state", int'(state), 3);
    chk("goal1 score1", int'(score1), 1);
    chk("goal1 move_en", int'(move_en), 0);
    ticks(60);
    chk("goal1 serve state", int'(state), 1);
    chk("goal1 serve_load", int'(serve_load), 1);
    chk("goal1 serve_x", int'(serve_x), 327);
    chk("goal1 serve_y", int'(serve_y), 271);
    ticks(60);
    chk("goal1 back to play", int'(state), 2);
  endtask

  task automatic test_simultaneous;
    goal1 = 1'b1;
    goal2 = 1'b1;
    step(1);
    goal1 = 1'b0;
    chk("both state", int'(state), 3);
    chk("both score1", int'(score1), 2);
    chk("both score2", int'(score2), 0);
    ticks(120);
    chk("held goal2 play", int'(state), 2);
    step(3);
    chk("held goal2 score2", int'(score2), 0);
    chk("held goal2 still play", int'(state), 2);
    goal2 = 1'b0;
    step(1);
  endtask

  task automatic test_match_end;
    for (int g = 1; g <= 5; g++) begin
      goal2 = 1'b1;
      step(1);
      goal2 = 1'b0;
      chk($sformatf("end score2 g%0d", g), int'(score2), g);
      ticks(60);
      if (g < 5) begin
        chk($sformatf("end serve_x g%0d", g), int'(serve_x), 600);
        ticks(60);
        chk($sformatf("end play g%0d", g), int'(state), 2);
      end else begin
        chk("end state over", int'(state), 4);
      end
    end
    chk("end winner", int'(winner), 2);
    chk("end score1", int'(score1), 2);
    chk("end move_en", int'(move_en), 0);
    step(5);
    chk("over held state", int'(state), 4);
    chk("over held score2", int'(score2), 5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("restart state", int'(state), 1);
    chk("restart score1", int'(score1), 0);
    chk("restart score2", int'(score2), 0);
    chk("restart winner", int'(winner), 0);
    chk("restart serve_x", int'(serve_x), 464);
    chk("restart serve_load", int'(serve_load), 1);
  endtask

  task automatic test_reset_mid_goal;
    ticks(60);
    chk("mid play", int'(state), 2);
    goal1 = 1'b1;
    step(1);
    goal1 = 1'b0;
    chk("mid goal state", int'(state), 3);
    ticks(30);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check_reset_values("midreset");
    goal1 = 1'b1;
    step(2);
    goal1 = 1'b0;
    chk("idle goal score1", int'(score1), 0);
    chk("idle goal state", int'(state), 0);
  endtask

  task automatic test_min_pause;
    start_b = 1'b1;
    tick_b  = 1'b1;
    step(1);
    start_b = 1'b0;
    tick_b  = 1'b0;
    chk("min serve entry", int'(state_b), 1);
    chk("min serve_load", int'(serve_load_b), 1);
    step(3);
    chk("min entry tick ignored", int'(state_b), 1);
    tick_b = 1'b1;
    step(1);
    tick_b = 1'b0;
    chk("min serve after tick", int'(state_b), 1);
    step(1);
    chk("min play", int'(state_b), 2);
    chk("min move_en", int'(move_en_b), 1);
  endtask

  initial begin
    step(1);
    test_reset;
    test_kickoff;
    test_single_goal;
    test_simultaneous;
    test_match_end;
    test_reset_mid_goal;
    test_min_pause;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
